crossbar_rr_sched: RTL and testbench
====================================

// Module: crossbar_rr_sched
// PURPOSE
//  Round-robin, packet-aware scheduler for the 4:4 input-queued crossbar.
//  - Inputs: the head-of-line state of each input FIFO, plus per-output backpressure.
//  - Outputs: the FIFO pop strobes and the registered per-output source selects for the crossbar datapath.
//  - Once a packet wins an output, the output stays locked to that input until EOP, so packets never interleave.
// PARAMETERS
//  NUM_PORTS   4  number of input queues and number of output ports
//  PORT_WIDTH  2  width of one port index; must equal log2(NUM_PORTS)
// PORTS
//  clk        in   1                     clock
//  rst        in   1                     synchronous reset, active-low
//  req_valid  in   NUM_PORTS             input FIFO i non-empty (head word valid)
//  req_dst    in   NUM_PORTS*PORT_WIDTH  head destination of input i, slice [i*PORT_WIDTH +: PORT_WIDTH]; ctrl[1:0]
//  req_eop    in   NUM_PORTS             head word of input i is the last word of its packet
//  out_ready  in   NUM_PORTS             output o may accept a word this cycle (downstream not nearly full)
//  grant_rd   out  NUM_PORTS             combinational pop strobe to input FIFO i
//  out_valid  out  NUM_PORTS             registered: output o carries a word this cycle
//  out_sel    out  NUM_PORTS*PORT_WIDTH  registered: input index driving output o
//  out_lock   out  NUM_PORTS             registered: output o is mid-packet (LOCKED state)
// BEHAVIOUR
//  Per-output state
//  - Each output o has a state (IDLE/LOCKED), a lock_src[o] and an rr_ptr[o].
//  - When rst=0 at a clock edge:
//    - every output returns to IDLE, lock_src=0, rr_ptr=0;
//    - out_valid=0, out_sel=0, out_lock=0.
//  - While rst=0, grant_rd is forced to 0.
//  - Reset mid-packet discards the lock; the partial packet is not tracked further.
//  Locked inputs
//  - in_locked[i] is true when any output is in LOCKED with lock_src==i.
//  - A locked input is never a candidate for any other output. The dst field of its non-first words is ignored.
//  IDLE, output o
//  - Candidates: every i with req_valid[i] && req_dst[i]==o && !in_locked[i].
//  - Winner: the first candidate scanning i = rr_ptr[o], rr_ptr[o]+1, ... (mod NUM_PORTS).
//  - A grant happens only if out_ready[o]=1 and at least one candidate exists. Then:
//    - grant_rd[w]=1 in the same cycle;
//    - next edge: out_valid[o]=1, out_sel[o]=w.
//  - If req_eop[w]=1, o stays IDLE and rr_ptr[o] <= (w+1) mod NUM_PORTS.
//  - Otherwise o goes to LOCKED, lock_src <= w, out_lock[o] <= 1, and rr_ptr is held.
//  LOCKED, output o
//  - Only lock_src can be granted, and only when req_valid[lock_src] && out_ready[o].
//  - Each grant pulses grant_rd, then out_valid/out_sel on the next edge.
//  - A granted word with req_eop=1 sends o to IDLE and sets rr_ptr[o] <= (lock_src+1) mod N.
//  - A FIFO bubble (req_valid=0) or out_ready=0 holds the lock. Other inputs wait.
//  General rules
//  - No grant to o in a cycle -> out_valid[o]=0 on the next edge; out_sel[o] holds its last value.
//  - Each input holds one head word, so it is granted to at most one output per cycle.
//  - All NUM_PORTS outputs may grant in the same cycle.
//  - Latency: request to grant_rd is 0 cycles (combinational); grant to out_valid is 1 cycle.
//  - Throughput: 1 word per output per cycle; a waiting contender is served within NUM_PORTS-1 packets.
//  - out_ready must be valid in the same cycle as its grant; grant_rd never depends on any FIFO flag other than req_valid.
//  - req_dst index arithmetic is modulo NUM_PORTS. rr_ptr wraps from NUM_PORTS-1 to 0.
// TESTING
//  T1:
//  - Stimulus: inputs 0 and 2 send back-to-back single-word packets to dst 1; out_ready=4'b1111; rr_ptr=0.
//  - Expect: grant_rd alternates 0001,0100,0001,...; out_valid[1]=1 every cycle; out_sel[1] = 0,2,0,2.
//  T2:
//  - Stimulus: input i sends to dst 3-i, all valid.
//  - Expect: grant_rd=4'b1111 in one cycle; next edge out_valid=4'b1111 and out_sel = {0,1,2,3} for outputs {3,2,1,0}.
//  T3:
//  - Stimulus: input 1 sends a 3-word packet to dst 3 (words 2-3 carry dst=0); input 0 waits to dst 3; rr_ptr[3]=1.
//  - Expect: input 1 gets 3 contiguous grants with out_lock[3]=1; output 0 is never granted to input 1;
//    input 0 granted on the 4th cycle; rr_ptr[3]=2 after EOP.
//  T4:
//  - Stimulus: input 2 is locked to output 0; req_valid[2]=0 for 3 cycles while input 3 requests dst 0.
//  - Expect: no grant to input 3; out_valid[0]=0 for 3 cycles; the lock holds; input 2 resumes.
//  T5:
//  - Stimulus: input 0 requests dst 2; out_ready[2]=0 for 5 cycles, then 1.
//  - Expect: grant_rd[0]=0 for 5 cycles; granted in cycle 6; out_valid[2] on the next edge.
//  T6:
//  - Stimulus: rst=0 for one edge mid-packet (out_lock[1]=1).
//  - Expect: grant_rd=0 during reset; after the edge out_valid=0, out_lock=0, out_sel=0, all rr_ptr=0;
//    the next request is arbitrated from IDLE.

Source files
------------

// File: rtl/crossbar_rr_sched.sv
// Round-robin, packet-aware scheduler for an input-queued NUM_PORTS x NUM_PORTS crossbar.
// Each output locks onto its winning input until EOP so packets never interleave.
module crossbar_rr_sched #(
    parameter int NUM_PORTS  = 4,
    parameter int PORT_WIDTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] req_dst,
    input  logic [NUM_PORTS-1:0]            req_eop,
    input  logic [NUM_PORTS-1:0]            out_ready,
    output logic [NUM_PORTS-1:0]            grant_rd,
    output logic [NUM_PORTS-1:0]            out_valid,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] out_sel,
    output logic [NUM_PORTS-1:0]            out_lock
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                state_q    [NUM_PORTS];
    state_e                state_d    [NUM_PORTS];
    logic [PORT_WIDTH-1:0] lock_src_q [NUM_PORTS];
    logic [PORT_WIDTH-1:0] lock_src_d [NUM_PORTS];
    logic [PORT_WIDTH-1:0] rr_ptr_q   [NUM_PORTS];
    logic [PORT_WIDTH-1:0] rr_ptr_d   [NUM_PORTS];
    logic [PORT_WIDTH-1:0] out_sel_q  [NUM_PORTS];
    logic [PORT_WIDTH-1:0] out_sel_d  [NUM_PORTS];
    logic [NUM_PORTS-1:0]  out_valid_q;
    logic [NUM_PORTS-1:0]  out_valid_d;

    logic [NUM_PORTS-1:0]  in_locked;
    logic [NUM_PORTS-1:0]  out_gnt;
    logic [PORT_WIDTH-1:0] win        [NUM_PORTS];

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                state_q[o]    <= IDLE;
                lock_src_q[o] <= '0;
                rr_ptr_q[o]   <= '0;
                out_sel_q[o]  <= '0;
            end
            out_valid_q <= '0;
        end else begin
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                state_q[o]    <= state_d[o];
                lock_src_q[o] <= lock_src_d[o];
                rr_ptr_q[o]   <= rr_ptr_d[o];
                out_sel_q[o]  <= out_sel_d[o];
            end
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        in_locked = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            if (state_q[o] == LOCKED) in_locked[lock_src_q[o]] = 1'b1;
        end
    end

    // Per-output arbitration: a locked input never shows up as a candidate elsewhere,
    // and an idle input only targets its own req_dst, so no input is granted twice.
    always_comb begin
        logic [PORT_WIDTH-1:0] idx;
        logic                  found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            out_gnt[o] = 1'b0;
            win[o]     = '0;
            if (state_q[o] == LOCKED) begin
                win[o]     = lock_src_q[o];
                out_gnt[o] = req_valid[lock_src_q[o]] && out_ready[o];
            end else begin
                found = 1'b0;
                for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                    idx = rr_ptr_q[o] + PORT_WIDTH'(k);
                    if (!found && req_valid[idx] && !in_locked[idx] &&
                        req_dst[int'(idx)*PORT_WIDTH +: PORT_WIDTH] == PORT_WIDTH'(o)) begin
                        found  = 1'b1;
                        win[o] = idx;
                    end
                end
                out_gnt[o] = found && out_ready[o];
            end
        end
    end

    // Next-state logic
    always_comb begin
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            state_d[o]     = state_q[o];
            lock_src_d[o]  = lock_src_q[o];
            rr_ptr_d[o]    = rr_ptr_q[o];
            out_sel_d[o]   = out_sel_q[o];
            out_valid_d[o] = out_gnt[o];
            if (out_gnt[o]) begin
                out_sel_d[o] = win[o];
                if (req_eop[win[o]]) begin
                    state_d[o]  = IDLE;
                    rr_ptr_d[o] = win[o] + 1'b1;
                end else begin
                    state_d[o]    = LOCKED;
                    lock_src_d[o] = win[o];
                end
            end
        end
    end

    // Outputs
    always_comb begin
        grant_rd = '0;
        out_lock = '0;
        out_sel  = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            if (out_gnt[o] && rst) grant_rd[win[o]] = 1'b1;
            out_lock[o] = (state_q[o] == LOCKED);
            out_sel[o*PORT_WIDTH +: PORT_WIDTH] = out_sel_q[o];
        end
        out_valid = out_valid_q;
    end

endmodule

// File: tb/tb_crossbar_rr_sched.sv
// Directed self-checking bench for crossbar_rr_sched: each vector drives one cycle and
// checks the combinational grant plus the registered outputs after the following edge.
module tb_crossbar_rr_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid;
    logic [7:0] req_dst;
    logic [3:0] req_eop;
    logic [3:0] out_ready;
    logic [3:0] grant_rd;
    logic [3:0] out_valid;
    logic [7:0] out_sel;
    logic [3:0] out_lock;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] valid;
        logic [7:0] dst;
        logic [3:0] eop;
        logic [3:0] rdy;
        logic [3:0] g;
        logic [3:0] v;
        logic [7:0] s;
        logic [3:0] l;
    } vec_t;

    crossbar_rr_sched #(.NUM_PORTS(4), .PORT_WIDTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_dst   (req_dst),
        .req_eop   (req_eop),
        .out_ready (out_ready),
        .grant_rd  (grant_rd),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .out_lock  (out_lock)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [3:0] valid, logic [7:0] dst, logic [3:0] eop,
                                logic [3:0] rdy, logic [3:0] g, logic [3:0] v,
                                logic [7:0] s, logic [3:0] l);
        vec_t t;
        t.valid = valid; t.dst = dst; t.eop = eop; t.rdy = rdy;
        t.g = g; t.v = v; t.s = s; t.l = l;
        return t;
    endfunction

    task automatic drive(vec_t t);
        req_valid = t.valid;
        req_dst   = t.dst;
        req_eop   = t.eop;
        out_ready = t.rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0; req_dst = '0; req_eop = '0; out_ready = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b1111; req_dst = 8'h1B; req_eop = 4'b1111; out_ready = 4'b1111;
        #1;
        checks++;
        if (grant_rd !== 4'b0000) begin
            failures++; $display("FAIL reset.grant got=%b exp=0000", grant_rd);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 4'b0000 || out_sel !== 8'h00 || out_lock !== 4'b0000) begin
            failures++;
            $display("FAIL reset.outs got v=%b s=%h l=%b exp v=0000 s=00 l=0000",
                     out_valid, out_sel, out_lock);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_rr_alternate();
        vec_t tv[$];
        do_reset();
        for (int k = 0; k < 4; k++)
            tv.push_back(mk(4'b0101, 8'b00_01_00_01, 4'b1111, 4'b1111,
                            (k % 2 == 0) ? 4'b0001 : 4'b0100, 4'b0010,
                            (k % 2 == 0) ? 8'h00 : 8'h08, 4'b0000));
        foreach (tv[k]) begin
            drive(tv[k]); #1;
            checks++;
            if (grant_rd !== tv[k].g) begin
                failures++; $display("FAIL rr[%0d].grant got=%b exp=%b", k, grant_rd, tv[k].g);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== tv[k].v || out_sel !== tv[k].s || out_lock !== tv[k].l) begin
                failures++;
                $display("FAIL rr[%0d].outs got v=%b s=%h l=%b exp v=%b s=%h l=%b",
                         k, out_valid, out_sel, out_lock, tv[k].v, tv[k].s, tv[k].l);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_all_parallel();
        vec_t tv[$];
        do_reset();
        tv.push_back(mk(4'b1111, 8'h1B, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 8'h1B, 4'b0000));
        tv.push_back(mk(4'b0000, 8'h1B, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 8'h1B, 4'b0000));
        foreach (tv[k]) begin
            drive(tv[k]); #1;
            checks++;
            if (grant_rd !== tv[k].g) begin
                failures++; $display("FAIL par[%0d].grant got=%b exp=%b", k, grant_rd, tv[k].g);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== tv[k].v || out_sel !== tv[k].s || out_lock !== tv[k].l) begin
                failures++;
                $display("FAIL par[%0d].outs got v=%b s=%h l=%b exp v=%b s=%h l=%b",
                         k, out_valid, out_sel, out_lock, tv[k].v, tv[k].s, tv[k].l);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_packet_lock();
        vec_t tv[$];
        do_reset();
        // single-word packet from input 0 moves rr_ptr[3] to 1
        tv.push_back(mk(4'b0001, 8'b00_00_00_11, 4'b0001, 4'b1111, 4'b0001, 4'b1000, 8'h00, 4'b0000));
        tv.push_back(mk(4'b0011, 8'b00_00_11_11, 4'b0001, 4'b1111, 4'b0010, 4'b1000, 8'h40, 4'b1000));
        tv.push_back(mk(4'b0011, 8'b00_00_00_11, 4'b0001, 4'b1111, 4'b0010, 4'b1000, 8'h40, 4'b1000));
        tv.push_back(mk(4'b0011, 8'b00_00_00_11, 4'b0011, 4'b1111, 4'b0010, 4'b1000, 8'h40, 4'b0000));
        // rr_ptr[3]=2 now: input 0 beats a fresh request from input 1
        tv.push_back(mk(4'b0011, 8'b00_00_11_11, 4'b0011, 4'b1111, 4'b0001, 4'b1000, 8'h00, 4'b0000));
        foreach (tv[k]) begin
            drive(tv[k]); #1;
            checks++;
            if (grant_rd !== tv[k].g) begin
                failures++; $display("FAIL lock[%0d].grant got=%b exp=%b", k, grant_rd, tv[k].g);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== tv[k].v || out_sel !== tv[k].s || out_lock !== tv[k].l) begin
                failures++;
                $display("FAIL lock[%0d].outs got v=%b s=%h l=%b exp v=%b s=%h l=%b",
                         k, out_valid, out_sel, out_lock, tv[k].v, tv[k].s, tv[k].l);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bubble_hold();
        vec_t tv[$];
        do_reset();
        tv.push_back(mk(4'b0100, 8'b00_00_00_00, 4'b0000, 4'b1111, 4'b0100, 4'b0001, 8'h02, 4'b0001));
        for (int k = 0; k < 3; k++)
            tv.push_back(mk(4'b1000, 8'b00_00_00_00, 4'b1000, 4'b1111, 4'b0000, 4'b0000, 8'h02, 4'b0001));
        tv.push_back(mk(4'b1100, 8'b00_11_00_00, 4'b1100, 4'b1111, 4'b0100, 4'b0001, 8'h02, 4'b0000));
        tv.push_back(mk(4'b1000, 8'b00_00_00_00, 4'b1000, 4'b1111, 4'b1000, 4'b0001, 8'h03, 4'b0000));
        foreach (tv[k]) begin
            drive(tv[k]); #1;
            checks++;
            if (grant_rd !== tv[k].g) begin
                failures++; $display("FAIL bubble[%0d].grant got=%b exp=%b", k, grant_rd, tv[k].g);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== tv[k].v || out_sel !== tv[k].s || out_lock !== tv[k].l) begin
                failures++;
                $display("FAIL bubble[%0d].outs got v=%b s=%h l=%b exp v=%b s=%h l=%b",
                         k, out_valid, out_sel, out_lock, tv[k].v, tv[k].s, tv[k].l);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        vec_t tv[$];
        do_reset();
        for (int k = 0; k < 5; k++)
            tv.push_back(mk(4'b0001, 8'b00_00_00_10, 4'b0001, 4'b1011, 4'b0000, 4'b0000, 8'h00, 4'b0000));
        tv.push_back(mk(4'b0001, 8'b00_00_00_10, 4'b0001, 4'b1111, 4'b0001, 4'b0100, 8'h00, 4'b0000));
        foreach (tv[k]) begin
            drive(tv[k]); #1;
            checks++;
            if (grant_rd !== tv[k].g) begin
                failures++; $display("FAIL bp[%0d].grant got=%b exp=%b", k, grant_rd, tv[k].g);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== tv[k].v || out_sel !== tv[k].s || out_lock !== tv[k].l) begin
                failures++;
                $display("FAIL bp[%0d].outs got v=%b s=%h l=%b exp v=%b s=%h l=%b",
                         k, out_valid, out_sel, out_lock, tv[k].v, tv[k].s, tv[k].l);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_packet();
        vec_t t;
        do_reset();
        t = mk(4'b1000, 8'b01_00_00_00, 4'b0000, 4'b1111, 4'b1000, 4'b0010, 8'h0C, 4'b0010);
        drive(t); #1;
        checks++;
        if (grant_rd !== t.g) begin
            failures++; $display("FAIL midrst.lock_grant got=%b exp=%b", grant_rd, t.g);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== t.v || out_sel !== t.s || out_lock !== t.l) begin
            failures++;
            $display("FAIL midrst.locked got v=%b s=%h l=%b exp v=%b s=%h l=%b",
                     out_valid, out_sel, out_lock, t.v, t.s, t.l);
        end
        @(negedge clk);
        rst = 1'b0; #1;
        checks++;
        if (grant_rd !== 4'b0000) begin
            failures++; $display("FAIL midrst.grant_in_reset got=%b exp=0000", grant_rd);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 4'b0000 || out_sel !== 8'h00 || out_lock !== 4'b0000) begin
            failures++;
            $display("FAIL midrst.cleared got v=%b s=%h l=%b exp v=0000 s=00 l=0000",
                     out_valid, out_sel, out_lock);
        end
        @(negedge clk);
        rst = 1'b1;
        // with the lock gone and rr_ptr[1]=0, input 0 beats input 3
        t = mk(4'b1001, 8'b01_00_00_01, 4'b1001, 4'b1111, 4'b0001, 4'b0010, 8'h00, 4'b0000);
        drive(t); #1;
        checks++;
        if (grant_rd !== t.g) begin
            failures++; $display("FAIL midrst.rearb_grant got=%b exp=%b", grant_rd, t.g);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== t.v || out_sel !== t.s || out_lock !== t.l) begin
            failures++;
            $display("FAIL midrst.rearb got v=%b s=%h l=%b exp v=%b s=%h l=%b",
                     out_valid, out_sel, out_lock, t.v, t.s, t.l);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        req_valid = '0; req_dst = '0; req_eop = '0; out_ready = '0;
        test_reset();
        test_rr_alternate();
        test_all_parallel();
        test_packet_lock();
        test_bubble_hold();
        test_backpressure();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
